// File: rtl/multi_bus_pkg.sv
// Shared widths, default slave address map and arbiter state type for multi_bus.
package multi_bus_pkg;

    localparam int AW = 16;
    localparam int DW = 64;

    // Slave 0 owns 0x0000-0x07FF, slave 1 owns 0x7000-0x71FF.
    localparam logic [31:0] DEF_S_BASE = {16'h7000, 16'h0000};
    localparam logic [31:0] DEF_S_MASK = {16'hFE00, 16'hF800};

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/multi_bus_rr_arb.sv
// Round-robin bus arbiter with registered one-hot grant.
// Optional grant hold limit enabled by MULTI_BUS_HOLD_LIMIT_EN.
//
// state     | meaning
// ARB_IDLE  | no master owns the bus
// ARB_OWNED | exactly one grant bit is set
module multi_bus_rr_arb
    import multi_bus_pkg::*;
#(
    parameter int N_MASTER = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_MASTER-1:0] req,
    output logic [N_MASTER-1:0] grant,
    output arb_state_e          state
);

    localparam int PW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    arb_state_e          state_nxt;
    logic [N_MASTER-1:0] grant_nxt;
    logic [N_MASTER-1:0] cand;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_nxt;
    logic [PW-1:0]       pick;
    logic [PW-1:0]       idx;
    logic [PW:0]         sum;
    logic                keep;
    logic                expire;
    logic                found;

    assign keep = |(grant & req);

`ifdef MULTI_BUS_HOLD_LIMIT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_nxt;

    // Down-counter loaded on every grant change; terminal count means the
    // owner has used up HOLD_MAX cycles.
    assign expire = keep && (hold_cnt == '0) && |(req & ~grant);

    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (grant_nxt != grant) begin
            hold_cnt_nxt = CW'(HOLD_MAX - 1);
        end else if ((state == ARB_OWNED) && (hold_cnt != '0)) begin
            hold_cnt_nxt = hold_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end
`else
    assign expire = 1'b0;

    // HOLD_MAX only matters to the hold limiter.
    if (HOLD_MAX < 1) begin : g_hold_max_unused
    end
`endif

    // First candidate at or after ptr, wrapping modulo N_MASTER.
    always_comb begin
        cand  = expire ? (req & ~grant) : req;
        found = 1'b0;
        pick  = ptr;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_MASTER)) begin
                sum = sum - (PW+1)'(N_MASTER);
            end
            idx = sum[PW-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        if ((state == ARB_IDLE) || !keep || expire) begin
            if (found) begin
                state_nxt = ARB_OWNED;
                grant_nxt = N_MASTER'(1) << pick;
                ptr_nxt   = (pick == PW'(N_MASTER - 1)) ? '0 : pick + PW'(1);
            end else begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule

// File: rtl/multi_bus.sv
// Shared multi-master bus: arbitration, slave address decode and read-data return.
// Define MULTI_BUS_HOLD_LIMIT_EN to bound how long one master may hold the grant.
module multi_bus
    import multi_bus_pkg::*;
#(
    parameter int                    N_MASTER = 2,
    parameter int                    N_SLAVE  = 2,
    parameter logic [N_SLAVE*AW-1:0] S_BASE   = DEF_S_BASE,
    parameter logic [N_SLAVE*AW-1:0] S_MASK   = DEF_S_MASK,
    parameter int                    HOLD_MAX = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_MASTER-1:0]    m_req,
    input  logic [N_MASTER-1:0]    m_wr,
    input  logic [N_MASTER*AW-1:0] m_addr,
    input  logic [N_MASTER*DW-1:0] m_dout,
    output logic [N_MASTER-1:0]    m_grant,
    output logic [DW-1:0]          m_din,
    output logic [N_SLAVE-1:0]     s_sel,
    output logic [AW-1:0]          s_addr,
    output logic                   s_wr,
    output logic [DW-1:0]          s_din,
    input  logic [N_SLAVE*DW-1:0]  s_dout
);

    localparam int SW = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

    arb_state_e    state;
    logic          owned;
    logic          hit;
    logic [SW-1:0] sel_idx;
    logic [SW-1:0] rd_idx;
    logic          rd_vld;

    multi_bus_rr_arb #(
        .N_MASTER (N_MASTER),
        .HOLD_MAX (HOLD_MAX)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (m_req),
        .grant   (m_grant),
        .state   (state)
    );

    assign owned = (state == ARB_OWNED);

    // Grant is one-hot, so an OR of gated masters is a clean mux.
    always_comb begin
        s_addr = '0;
        s_wr   = 1'b0;
        s_din  = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (m_grant[i]) begin
                s_addr = s_addr | m_addr[i*AW +: AW];
                s_wr   = s_wr | m_wr[i];
                s_din  = s_din | m_dout[i*DW +: DW];
            end
        end
    end

    // Scanning downwards lets the lowest matching slave win on overlap.
    always_comb begin
        hit     = 1'b0;
        sel_idx = '0;
        for (int k = N_SLAVE - 1; k >= 0; k--) begin
            if (owned && ((s_addr & S_MASK[k*AW +: AW]) == S_BASE[k*AW +: AW])) begin
                hit     = 1'b1;
                sel_idx = SW'(k);
            end
        end
        s_sel = hit ? (N_SLAVE'(1) << sel_idx) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld <= 1'b0;
            rd_idx <= '0;
        end else begin
            rd_vld <= hit && !s_wr;
            rd_idx <= sel_idx;
        end
    end

    always_comb begin
        m_din = '0;
        for (int k = 0; k < N_SLAVE; k++) begin
            if (rd_vld && (rd_idx == SW'(k))) begin
                m_din = s_dout[k*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_multi_bus.sv
// Self-checking bench for multi_bus: directed scenarios followed by random traffic
// against a cycle-level reference model of ownership, decode and read return.
`timescale 1ns/1ps
module tb_multi_bus;

    localparam int NM   = 2;
    localparam int NS   = 2;
    localparam int HOLD = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NM-1:0]     m_req;
    logic [NM-1:0]     m_wr;
    logic [NM*16-1:0]  m_addr;
    logic [NM*64-1:0]  m_dout;
    logic [NM-1:0]     m_grant;
    logic [63:0]       m_din;
    logic [NS-1:0]     s_sel;
    logic [15:0]       s_addr;
    logic              s_wr;
    logic [63:0]       s_din;
    logic [NS*64-1:0]  s_dout;

    logic [15:0] sb [NS] = '{16'h0000, 16'h7000};
    logic [15:0] sm [NS] = '{16'hF800, 16'hFE00};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current owner (-1 = none), search start, cycles held,
    // pending read slave.
    int owner, start, held, pend_slave;
    int n_owner, n_start, n_held, n_pend_slave;

    multi_bus #(
        .N_MASTER (NM),
        .N_SLAVE  (NS),
        .S_BASE   ({16'h7000, 16'h0000}),
        .S_MASK   ({16'hFE00, 16'hF800}),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m_req   (m_req),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_dout  (m_dout),
        .m_grant (m_grant),
        .m_din   (m_din),
        .s_sel   (s_sel),
        .s_addr  (s_addr),
        .s_wr    (s_wr),
        .s_din   (s_din),
        .s_dout  (s_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int slave_of(input logic [15:0] a);
        for (int k = 0; k < NS; k++) begin
            if ((a & sm[k]) == sb[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1; start = 0; held = 0; pend_slave = -1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(m_grant), 64'd0);
        chk({tag, "_sel"},   64'(s_sel),   64'd0);
        chk({tag, "_addr"},  64'(s_addr),  64'd0);
        chk({tag, "_wr"},    64'(s_wr),    64'd0);
        chk({tag, "_din"},   s_din,        64'd0);
        chk({tag, "_mdin"},  m_din,        64'd0);
    endtask

    task automatic check_cycle();
        logic [15:0]   ea;
        logic          ew;
        logic [63:0]   ed;
        logic [NM-1:0] cand;
        int            sl;
        bit            keep, expire;
        ea = '0; ew = 1'b0; ed = '0; sl = -1;
        if (owner >= 0) begin
            ea = m_addr[owner*16 +: 16];
            ew = m_wr[owner];
            ed = m_dout[owner*64 +: 64];
            sl = slave_of(ea);
        end
        chk("m_grant", 64'(m_grant), (owner >= 0) ? (64'd1 << owner) : 64'd0);
        chk("s_addr",  64'(s_addr),  64'(ea));
        chk("s_wr",    64'(s_wr),    64'(ew));
        chk("s_din",   s_din,        ed);
        chk("s_sel",   64'(s_sel),   (sl >= 0) ? (64'd1 << sl) : 64'd0);
        chk("m_din",   m_din,        (pend_slave >= 0) ? s_dout[pend_slave*64 +: 64] : 64'd0);

        n_pend_slave = (owner >= 0 && !ew) ? sl : -1;
        n_owner = owner; n_start = start; n_held = held;
        keep   = (owner >= 0) && m_req[owner];
        expire = 1'b0;
`ifdef MULTI_BUS_HOLD_LIMIT_EN
        if (keep && held >= HOLD && (m_req & ~(NM'(1) << owner)) != '0) expire = 1'b1;
`endif
        if (keep && !expire) begin
            n_held = held + 1;
        end else begin
            cand = m_req;
            if (expire) cand[owner] = 1'b0;
            n_owner = -1;
            for (int k = 0; k < NM; k++) begin
                if (n_owner < 0 && cand[(start + k) % NM]) n_owner = (start + k) % NM;
            end
            if (n_owner >= 0) begin
                n_start = (n_owner + 1) % NM;
                n_held  = 1;
            end else begin
                n_held = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        owner = n_owner; start = n_start; held = n_held; pend_slave = n_pend_slave;
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        #1 reset_n = 1'b0;
        model_reset();
        #1 chk_all_zero(tag);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0;
        m_req = '0; m_wr = '0; m_addr = '0; m_dout = '0;
        s_dout = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        #12 chk_all_zero("rst");
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Single read by M0 of slave 0
        s_dout = {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        m_req = 2'b01; m_addr[15:0] = 16'h0010; m_dout[63:0] = 64'h1111;
        tick();
        chk("r30_grant", 64'(m_grant), 64'h1);
        chk("r30_sel",   64'(s_sel),   64'h1);
        tick();
        chk("r30_din",   m_din,        64'h0123_4567_89AB_CDEF);

        // Round-robin order from reset
        pulse_reset("r31_rst");
        m_req = 2'b11; m_addr[31:16] = 16'h7010;
        tick();  chk("r31_first", 64'(m_grant), 64'h1);
        m_req = 2'b10;
        tick();  chk("r31_hand",  64'(m_grant), 64'h2);
        m_req = 2'b11;
        tick();  chk("r31_keep",  64'(m_grant), 64'h2);
        m_req = 2'b01;
        tick();  chk("r31_back",  64'(m_grant), 64'h1);

        // M1 write to slave 1
        m_req = 2'b10; m_wr = 2'b10;
        m_addr[31:16] = 16'h7008; m_dout[127:64] = 64'hDEAD_BEEF;
        tick();
        chk("r32_sel", 64'(s_sel), 64'h2);
        chk("r32_wr",  64'(s_wr),  64'h1);
        chk("r32_din", s_din,      64'hDEAD_BEEF);
        tick();
        chk("r32_mdin", m_din, 64'd0);

        // M1 read of unmapped address
        m_wr = 2'b00; m_addr[31:16] = 16'h4000;
        #1 chk("r33_sel", 64'(s_sel), 64'd0);
        tick();
        chk("r33_mdin", m_din, 64'd0);

        // Hold limit behaviour
        m_req = 2'b00;
        tick();
        m_req = 2'b01; m_addr[15:0] = 16'h0100;
        tick();
        chk("r34_m0", 64'(m_grant), 64'h1);
        m_req = 2'b11;
        cnt = 1;
        for (int i = 0; i < 100 && m_grant == 2'b01; i++) begin
            tick();
            if (m_grant == 2'b01) cnt++;
        end
`ifdef MULTI_BUS_HOLD_LIMIT_EN
        chk("r34_hold_cycles", 64'(cnt), 64'(HOLD));
        chk("r34_pass",        64'(m_grant), 64'h2);
`else
        chk("r34_keep_cycles", 64'(cnt), 64'd101);
        chk("r34_keep",        64'(m_grant), 64'h1);
`endif

        // Reset while M1 owns the bus
        m_req = 2'b10;
        tick();
        chk("r35_m1", 64'(m_grant), 64'h2);
        m_req = 2'b11;
        pulse_reset("r35_rst");
        tick();
        chk("r35_first", 64'(m_grant), 64'h1);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 7) == 0) m_req[i] = ~m_req[i];
                if ($urandom_range(0, 3) == 0) m_wr[i] = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 4))
                    0:       m_addr[i*16 +: 16] = 16'h0010;
                    1:       m_addr[i*16 +: 16] = 16'($urandom_range(0, 2047));
                    2:       m_addr[i*16 +: 16] = 16'h7000 | 16'($urandom_range(0, 511));
                    3:       m_addr[i*16 +: 16] = 16'h4000;
                    default: m_addr[i*16 +: 16] = 16'($urandom);
                endcase
                m_dout[i*64 +: 64] = {$urandom, $urandom};
            end
            if ($urandom_range(0, 1) == 0) s_dout = {$urandom, $urandom, $urandom, $urandom};
            if (c == 250) pulse_reset("rnd_rst");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_bus.md
MULTI_BUS -- requirements
Module: multi_bus

Interface
REQ-001 SHALL have parameter N_MASTER, default 2: number of bus masters (1..8).
REQ-002 SHALL have parameter N_SLAVE, default 2: number of slaves (1..8).
REQ-003 SHALL have parameter S_BASE, default {16'h7000,16'h0000}: packed N_SLAVE x 16 base addresses, slave 0 in the LSBs.
REQ-004 SHALL have parameter S_MASK, default {16'hFE00,16'hF800}: packed N_SLAVE x 16 decode masks.
REQ-005 SHALL have parameter HOLD_MAX, default 16: grant hold limit in cycles (used only under REQ-024).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 m_req  input  N_MASTER  per-master bus request.
REQ-009 m_wr  input  N_MASTER  per-master write strobe (1 = write, 0 = read).
REQ-010 m_addr  input  N_MASTER*16  per-master address, packed.
REQ-011 m_dout  input  N_MASTER*64  per-master write data, packed.
REQ-012 m_grant  output  N_MASTER  registered one-hot grant.
REQ-013 m_din  output  64  read data returned to the masters (shared).
REQ-014 s_sel  output  N_SLAVE  one-hot slave select.
REQ-015 s_addr / s_wr / s_din  output  16 / 1 / 64  owner's address, write strobe, write data.
REQ-016 s_dout  input  N_SLAVE*64  per-slave read data, packed.

Function
REQ-017 Arbitration SHALL occur on each rising edge at which no master is both granted and requesting; the new grant SHALL go to the first requester in round-robin order, starting at (last owner + 1) mod N_MASTER.
REQ-018 Owner dropping m_req SHALL lose the grant at the next edge; the same edge SHALL grant the next requester if any, else m_grant = 0.
REQ-019 While m_grant[i]=1, s_addr, s_wr, s_din SHALL combinationally follow master i; with no owner they SHALL be 0.
REQ-020 s_sel[k] SHALL be 1 iff an owner exists and (s_addr & S_MASK[k]) == S_BASE[k]; overlapping matches SHALL resolve to the lowest k; no match SHALL assert no s_sel.
REQ-021 A read (s_wr=0, some s_sel high) SHALL register the selected slave index; in the following cycle m_din SHALL equal s_dout of that slave (one-cycle read latency); otherwise m_din SHALL be 0.
REQ-022 Writes and unmapped accesses SHALL leave m_din = 0 in the next cycle.
REQ-023 Arbiter states: IDLE (no owner), OWNED (one owner); IDLE->OWNED on any request, OWNED->IDLE on owner release with no other requester, OWNED->OWNED with handover otherwise.

Configuration
REQ-024 With MULTI_BUS_HOLD_LIMIT_EN defined, a hold counter SHALL count owner cycles; once it reaches HOLD_MAX while another master requests, the grant SHALL pass round-robin to that requester at the next edge and the counter SHALL clear on every grant change.
REQ-025 Without MULTI_BUS_HOLD_LIMIT_EN, an owner SHALL keep the grant indefinitely while requesting, and no counter SHALL exist.

Reset
REQ-026 On reset_n low, asynchronously: m_grant = 0, round-robin pointer = master 0 first, read-index register = none, hold counter = 0; m_din, s_sel, s_addr, s_wr, s_din SHALL be 0.
REQ-027 Reset asserted mid-transfer SHALL abort it; first grant after release SHALL go to the lowest-index requester.

Structure
REQ-028 A package multi_bus_pkg SHALL hold address width 16, data width 64, the default S_BASE/S_MASK map and the arbiter state enum.
REQ-029 Round-robin selection and hold counter SHALL be the sub-module multi_bus_rr_arb; decode and data muxing SHALL stay in multi_bus.

Verification
REQ-030 Reset, M0 req read 0x0010 -> m_grant=2'b01 next edge, s_sel=2'b01, m_din = slave-0 data one cycle after the read.
REQ-031 M0 and M1 request together from reset -> M0 granted; M0 drops req -> M1 granted at that edge; both re-request -> M0 next after M1 releases.
REQ-032 M1 write 0x7008 data 64'hDEAD_BEEF -> s_sel=2'b10, s_wr=1, s_din=64'hDEAD_BEEF, next-cycle m_din=0.
REQ-033 Read of unmapped 0x4000 -> s_sel=0, m_din=0 next cycle.
REQ-034 MULTI_BUS_HOLD_LIMIT_EN, HOLD_MAX=16: M0 holds req, M1 requests -> M1 granted after 16 M0 cycles; without macro M0 keeps grant for 100 cycles.
REQ-035 reset_n pulsed low during M1 ownership -> all outputs 0 immediately; M0/M1 both requesting after release -> M0 granted.
